// File: rtl/multicycle_control.sv
// multicycle_control: control unit for a multicycle RV32 subset datapath
// (lw, sw, R-type, I-type ALU, beq/bne, jal).
// Moore-style state outputs, except for two combinational terms:
// PCWrite/IRWrite follow mem_ready in FETCH, and PCWrite in BRANCH follows zero.
// All outputs are forced to 0 while rst_n is low.
// Optional feature: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to build a TRAP state.
// An unknown opcode then parks the controller with illegal=1 until reset.
// Without the macro, an unknown opcode is treated as a NOP and illegal is tied to 0.
module multicycle_control #(
   parameter int ALUCTRL_W = 3,
   parameter int RET_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic                 RegWrite,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [RET_W-1:0]     retired,
   output logic                 illegal
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWRITE = 4'd4,
      MEMWB    = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      , TRAP   = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t      state;
   state_t      next_state;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [1:0]  alu_op;
   logic        take_branch;
   logic        retire;
   logic        unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   // ALU operation decode: ALUOp selects add/sub directly or defers to funct3.
   function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [2:0] f3,
                                             input logic op5, input logic f7b5);
      logic [2:0] ctl;
      case (op)
         2'b00: ctl = 3'b000;
         2'b01: ctl = 3'b001;
         2'b10: begin
            case (f3)
               3'b000:  ctl = (op5 & f7b5) ? 3'b001 : 3'b000;
               3'b010:  ctl = 3'b101;
               3'b110:  ctl = 3'b011;
               3'b111:  ctl = 3'b010;
               default: ctl = 3'b000;
            endcase
         end
         default: ctl = 3'b000;
      endcase
      return ctl;
   endfunction

   // State register: reset always restarts at FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; also flags instruction completion for the retire counter.
   always_comb begin
      next_state = state;
      case (state)
         FETCH:    next_state = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = MEMADR;
               OP_R:              next_state = EXECR;
               OP_I:              next_state = EXECI;
               OP_BRANCH:         next_state = BRANCH;
               OP_JAL:            next_state = JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               default:           next_state = TRAP;
`else
               default:           next_state = FETCH;
`endif
            endcase
         end
         MEMADR:   next_state = opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
         MEMWB:    next_state = FETCH;
         EXECR:    next_state = ALUWB;
         EXECI:    next_state = ALUWB;
         ALUWB:    next_state = FETCH;
         BRANCH:   next_state = FETCH;
         JAL:      next_state = ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         TRAP:     next_state = TRAP;
`endif
         default:  next_state = FETCH;
      endcase
      retire = (next_state == FETCH) && (state inside {MEMWB, MEMWRITE, ALUWB, BRANCH});
   end

   // Retired-instruction counter; wraps naturally at 2^RET_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (retire) begin
         retired <= retired + RET_W'(1);
      end else begin
         retired <= retired;
      end
   end

   assign take_branch = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);

   // Output decode per state, held at 0 while reset is asserted.
   always_comb begin
      mem_req   = 1'b0;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      RegWrite  = 1'b0;
      alu_op    = 2'b00;
      illegal   = 1'b0;
      if (rst_n) begin
         case (state)
            FETCH: begin
               mem_req   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               ImmSrc  = 2'b10;
            end
            MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ImmSrc  = opcode[5] ? 2'b01 : 2'b00;
            end
            MEMREAD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            MEMWRITE: begin
               mem_req  = 1'b1;
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            MEMWB: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
            end
            EXECR: begin
               ALUSrcA = 2'b10;
               alu_op  = 2'b10;
            end
            EXECI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               alu_op  = 2'b10;
            end
            ALUWB: begin
               RegWrite = 1'b1;
            end
            BRANCH: begin
               ALUSrcA = 2'b10;
               alu_op  = 2'b01;
               ImmSrc  = 2'b10;
               PCWrite = take_branch;
            end
            JAL: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               ImmSrc  = 2'b11;
               PCWrite = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
               illegal = 1'b1;
            end
`endif
            default: begin
               mem_req = 1'b0;
            end
         endcase
      end else begin
         alu_op = 2'b00;
      end
      ALUControl = ALUCTRL_W'(alu_decode(alu_op, funct3, instr[5], instr[30]));
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (RET_W=4 to exercise counter wrap,
// ALUCTRL_W=4 to check the upper ALUControl bit stays 0).
module tb_multicycle_control;

   localparam logic [31:0] ADD  = 32'h002081B3;
   localparam logic [31:0] SUB  = 32'h402081B3;
   localparam logic [31:0] ORR  = 32'h0020E1B3;
   localparam logic [31:0] ANDR = 32'h0020F1B3;
   localparam logic [31:0] SLT  = 32'h0020A1B3;
   localparam logic [31:0] SLL  = 32'h002091B3;
   localparam logic [31:0] ADDI = 32'h40008093;
   localparam logic [31:0] LW   = 32'h0000A183;
   localparam logic [31:0] SW   = 32'h0030A223;
   localparam logic [31:0] BEQ  = 32'h00208063;
   localparam logic [31:0] BNE  = 32'h00209063;
   localparam logic [31:0] BLT  = 32'h0020C063;
   localparam logic [31:0] JALI = 32'h000000EF;
   localparam logic [31:0] ILL  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [3:0]  ALUControl;
   logic [3:0]  retired;
   logic [17:0] ctl_obs;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   multicycle_control #(.ALUCTRL_W(4), .RET_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
      .retired(retired), .illegal(illegal)
   );

   assign ctl_obs = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected control vector: mem_req PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc RegWrite ALUControl
   task automatic expc(input string tag, input logic mreq, input logic pcw, input logic adr,
                       input logic mw, input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [1:0] imm, input logic rw, input logic [3:0] ac);
      chk(tag, {14'd0, ctl_obs}, {14'd0, mreq, pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac});
   endtask

   task automatic e_fetch(input string t, input logic mr);
      expc(t, 1'b1, mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 4'h0);
   endtask
   task automatic e_decode(input string t);
      expc(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 4'h0);
   endtask
   task automatic e_zero(input string t);
      expc(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0);
   endtask
   task automatic e_aluwb(input string t);
      expc(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'h0);
   endtask
   task automatic e_memadr(input string t, input logic [1:0] imm);
      expc(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, 4'h0);
   endtask
   task automatic e_memread(input string t);
      expc(t, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0);
   endtask
   task automatic e_memwrite(input string t);
      expc(t, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0);
   endtask
   task automatic e_branch(input string t, input logic pcw);
      expc(t, 1'b0, pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 4'h1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [31:0] ins, input logic mr, input logic z);
      instr     = ins;
      mem_ready = mr;
      zero      = z;
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   // One ALU instruction with zero wait states; checks the EXEC-state decode and retire.
   task automatic run_alu(input string tag, input logic [31:0] ins, input logic is_i,
                          input logic [3:0] ac, input logic [3:0] ret);
      go(ins, 1'b1, 1'b0);
      tick();
      tick();
      if (is_i) expc({tag, ".execi"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, ac);
      else      expc({tag, ".execr"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, ac);
      tick();
      e_aluwb({tag, ".wb"});
      tick();
      chk({tag, ".ret"}, {28'd0, retired}, {28'd0, ret});
   endtask

   initial begin
      rst_n     = 1'b0;
      instr     = 32'd0;
      mem_ready = 1'b1;
      zero      = 1'b0;
      #2;
      e_zero("rst.gated");
      chk("rst.retired", {28'd0, retired}, 32'd0);
      chk("rst.illegal", {31'd0, illegal}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // add: FETCH, DECODE, EXECR, ALUWB
      go(ADD, 1'b1, 1'b0);
      e_fetch("add.fetch", 1'b1);
      tick();
      e_decode("add.decode");
      tick();
      expc("add.execr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 4'h0);
      tick();
      e_aluwb("add.aluwb");
      tick();
      chk("add.ret", {28'd0, retired}, 32'd1);

      // lw with one fetch wait and two MEMREAD waits; mem_ready pulses in DECODE/MEMADR are ignored
      go(LW, 1'b0, 1'b0);
      e_fetch("lw.fetchwait", 1'b0);
      tick();
      go(LW, 1'b1, 1'b0);
      e_fetch("lw.fetch", 1'b1);
      tick();
      e_decode("lw.decode");
      tick();
      e_memadr("lw.memadr", 2'b00);
      tick();
      go(LW, 1'b0, 1'b0);
      e_memread("lw.mr0");
      tick();
      e_memread("lw.mr1");
      tick();
      go(LW, 1'b1, 1'b0);
      e_memread("lw.mr2");
      tick();
      expc("lw.memwb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 4'h0);
      tick();
      e_fetch("lw.done", 1'b1);
      chk("lw.ret", {28'd0, retired}, 32'd2);

      // sw with one MEMWRITE wait
      go(SW, 1'b1, 1'b0);
      tick();
      tick();
      e_memadr("sw.memadr", 2'b01);
      tick();
      go(SW, 1'b0, 1'b0);
      e_memwrite("sw.mw0");
      tick();
      go(SW, 1'b1, 1'b0);
      e_memwrite("sw.mw1");
      tick();
      e_fetch("sw.done", 1'b1);
      chk("sw.ret", {28'd0, retired}, 32'd3);

      // beq: PCWrite follows zero combinationally
      go(BEQ, 1'b1, 1'b1);
      tick();
      tick();
      e_branch("beq.z1", 1'b1);
      go(BEQ, 1'b1, 1'b0);
      e_branch("beq.z0", 1'b0);
      go(BEQ, 1'b1, 1'b1);
      tick();
      chk("beq.ret", {28'd0, retired}, 32'd4);

      // bne: taken only when zero=0
      tick();
      tick();
      go(BNE, 1'b1, 1'b1);
      e_branch("bne.z1", 1'b0);
      go(BNE, 1'b1, 1'b0);
      e_branch("bne.z0", 1'b1);
      tick();
      chk("bne.ret", {28'd0, retired}, 32'd5);

      // blt (funct3 100): never writes PC
      go(BLT, 1'b1, 1'b1);
      tick();
      tick();
      e_branch("blt.z1", 1'b0);
      go(BLT, 1'b1, 1'b0);
      e_branch("blt.z0", 1'b0);
      tick();
      chk("blt.ret", {28'd0, retired}, 32'd6);

      // jal: FETCH, DECODE, JAL, ALUWB
      go(JALI, 1'b1, 1'b0);
      tick();
      tick();
      expc("jal.jal", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 1'b0, 4'h0);
      tick();
      e_aluwb("jal.aluwb");
      tick();
      chk("jal.ret", {28'd0, retired}, 32'd7);

      // ALU decode per funct3 / funct7b5
      run_alu("sub",  SUB,  1'b0, 4'h1, 4'd8);
      run_alu("or",   ORR,  1'b0, 4'h3, 4'd9);
      run_alu("and",  ANDR, 1'b0, 4'h2, 4'd10);
      run_alu("slt",  SLT,  1'b0, 4'h5, 4'd11);
      run_alu("sll",  SLL,  1'b0, 4'h0, 4'd12);
      run_alu("addi", ADDI, 1'b1, 4'h0, 4'd13);

      // unknown opcode
      go(ILL, 1'b1, 1'b0);
      tick();
      e_decode("ill.decode");
      tick();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      e_zero("ill.trap0");
      chk("ill.flag0", {31'd0, illegal}, 32'd1);
      tick();
      tick();
      e_zero("ill.trap2");
      chk("ill.flag2", {31'd0, illegal}, 32'd1);
`else
      e_fetch("ill.nop", 1'b1);
      chk("ill.ret", {28'd0, retired}, 32'd13);
      chk("ill.flag", {31'd0, illegal}, 32'd0);
`endif
      reset_pulse();
      e_fetch("rst2.fetch", 1'b1);
      chk("rst2.ret", {28'd0, retired}, 32'd0);
      chk("rst2.illegal", {31'd0, illegal}, 32'd0);

      // 16 R-type instructions: counter wraps 15 -> 0
      for (int i = 0; i < 16; i++) begin
         go(ADD, 1'b1, 1'b0);
         tick();
         tick();
         tick();
         tick();
         chk($sformatf("wrap.ret%0d", i), {28'd0, retired}, (i + 1) % 16);
      end

      // reset during MEMWRITE abandons the store
      go(SW, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      go(SW, 1'b0, 1'b0);
      e_memwrite("swrst.mw");
      rst_n = 1'b0;
      #1;
      e_zero("swrst.gated");
      mem_ready = 1'b1;
      tick();
      e_zero("swrst.held");
      chk("swrst.ret", {28'd0, retired}, 32'd0);
      rst_n = 1'b1;
      #1;
      e_fetch("swrst.fetch", 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 ALUCTRL_W, default 3, ALUControl width (>=3); bits above [2:0] driven 0.
REQ-002 RET_W, default 32, retired-instruction counter width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7b5 [30]).
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the requested access this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 PCWrite  output  1  PC register load enable.
REQ-010 AdrSrc  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-011 MemWrite  output  1  data memory write.
REQ-012 IRWrite  output  1  instruction register / OldPC load.
REQ-013 ResultSrc  output  2  00 ALUOut, 01 read data, 10 ALUResult.
REQ-014 ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1.
REQ-015 ALUSrcB  output  2  00 rs2, 01 immediate, 10 constant 4.
REQ-016 ImmSrc  output  2  00 I, 01 S, 10 B, 11 J.
REQ-017 RegWrite  output  1  register file write enable.
REQ-018 ALUControl  output  ALUCTRL_W  ALU operation.
REQ-019 retired  output  RET_W  retired-instruction count.
REQ-020 illegal  output  1  illegal-opcode trap flag.

Function
REQ-021 Registered states FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP; every output is 0 unless listed for the current state.
REQ-022 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; remain while mem_ready=0, else go to DECODE.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10; next state by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL; any other opcode follows REQ-041.
REQ-024 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=00 if opcode[5]=0 else 01; next state MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-025 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then go to MEMWB.
REQ-026 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, all held until mem_ready=1, then go to FETCH.
REQ-027 MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-028 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB; EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10, then go to ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-030 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, ImmSrc=10; PCWrite=(funct3=000 & zero)|(funct3=001 & !zero), combinational; other funct3 never write; then go to FETCH.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, ImmSrc=11, PCWrite=1, then go to ALUWB.
REQ-032 ALUOp is internal; ALUControl decode (combinational): ALUOp 00 gives 000 (add); 01 gives 001 (sub); 10 decodes funct3: 000 gives 001 if instr[5]&instr[30] else 000; 010 gives 101 (slt); 110 gives 011 (or); 111 gives 010 (and); any other funct3 gives 000.
REQ-033 mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE; a mem_ready pulse with mem_req=0 has no effect.
REQ-034 Latency in cycles with zero wait states: R/I-type 4, lw 5, sw 4, branch 3, jal 4; each wait cycle adds 1.
REQ-035 retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; wraps from 2^RET_W-1 to 0.

Reset
REQ-036 rst_n=0 asynchronously forces state=FETCH, retired=0 and illegal=0, and gates all outputs to 0 while rst_n is low.
REQ-037 Reset asserted mid-instruction abandons the instruction: no PCWrite, RegWrite or MemWrite after assertion, and no retired increment.
REQ-038 The first FETCH request (mem_req=1) occurs in the first cycle after rst_n deasserts.

Configuration
REQ-039 The macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN selects illegal-opcode handling.
REQ-040 With the macro defined: an unknown opcode in DECODE goes to TRAP; in TRAP, illegal=1 and all other outputs are 0; TRAP exits only on reset.
REQ-041 Without the macro: an unknown opcode in DECODE returns to FETCH as a NOP (no retired increment); the TRAP state is not built and illegal is tied to 0.

Verification
REQ-042 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 in cycle 4; retired 0->1.
REQ-043 lw (0x0000A183) with mem_ready low 2 cycles in MEMREAD -> mem_req/AdrSrc=1 held 3 cycles; MEMWB RegWrite=1 with ResultSrc=01; total 7 cycles.
REQ-044 beq with zero=1, then bne with zero=1 -> PCWrite=1 in BRANCH for beq only; both retire.
REQ-045 Opcode 0x7F -> with macro: illegal=1 held, mem_req=0 until rst_n pulse; without macro: back to FETCH, retired unchanged.
REQ-046 RET_W=4, 16 R-type instructions -> retired wraps 15->0; rst_n low during MEMWRITE -> MemWrite=0 immediately, state FETCH.
